video_fetch: RTL and testbench
==============================

VIDEO_FETCH -- requirements
Module: video_fetch

Interface
REQ-001 Parameter: ADDR_W, default 13, display-memory address width in bits.
REQ-002 Port: clk  in  1  pixel clock; all state changes on its rising edge.
REQ-003 Port: resetn  in  1  reset, asynchronous assertion, active-low.
REQ-004 Port: hsn  in  1  horizontal sync from frame timing, active-low.
REQ-005 Port: fsn  in  1  vertical sync from frame timing, active-low.
REQ-006 Port: preload  in  1  line-data preload strobe from frame timing.
REQ-007 Port: rowclear  in  1  character-row counter reset from frame timing.
REQ-008 Port: width  in  6  bytes per active line; legal values are 8, 16 and 32.
REQ-009 Port: graphics  in  1  1 = graphics mode, 0 = alphanumeric mode.
REQ-010 Port: base  in  ADDR_W  frame start address.
REQ-011 Port: mem_data  in  8  read data, valid exactly one cycle after rd.
REQ-012 Port: addr  out  ADDR_W  display-memory read address.
REQ-013 Port: rd  out  1  read strobe, one-cycle pulse.
REQ-014 Port: pixel  out  1  serial pixel, MSB of each byte first.
REQ-015 Port: active  out  1  high while pixel carries line data.

Function
REQ-016 Edge detection: registered previous values of preload and hsn; preload_rise = preload & ~prev; hsn_fall = ~hsn & prev.
REQ-017 Pixel divider div: width 32 -> 1, 16 -> 2, 8 -> 4; any other width -> 1.
REQ-018 Each byte occupies 8*div clocks; each bit is held for div clocks.
REQ-019 FSM states: IDLE, WAIT, SHIFT.
REQ-020 IDLE -> WAIT on preload_rise: rd=1 and addr=line_base in that cycle; hold register captures mem_data on the next edge.
REQ-021 WAIT: lasts 8 clocks, counted from the preload_rise cycle; then -> SHIFT.
REQ-022 SHIFT first cycle: shift register loads from hold; active=1; byte_idx=0; bit count=0.
REQ-023 SHIFT, first cycle of each byte: if byte_idx < width-1, issue rd with addr=line_base+byte_idx+1, and capture mem_data into hold one cycle later.
REQ-024 SHIFT, byte boundary: shift register reloads from hold and byte_idx increments, with no gap cycle.
REQ-025 SHIFT -> IDLE after the last bit of byte width-1 completes; then active=0, pixel=0, and line_done is set.
REQ-026 pixel is 0 whenever active=0.
REQ-027 Line advance occurs on hsn_fall when line_done=1, after which line_done clears.
REQ-028 In graphics mode, every line advance adds width to line_base.
REQ-029 In alphanumeric mode, a line advance adds width to line_base only if rowclear=1 at that hsn_fall; otherwise line_base is unchanged and the same bytes repeat.
REQ-030 hsn_fall with line_done=0 (blanking line) leaves line_base unchanged.
REQ-031 All address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
REQ-032 While fsn=0: line_base <= base, line_done <= 0, FSM is forced to IDLE, active=0, rd=0. This overrides any same-cycle line advance or preload_rise.
REQ-033 preload_rise during WAIT or SHIFT is ignored; no restart and no extra rd.
REQ-034 Outputs addr, rd, pixel and active are registered.
REQ-035 addr holds its last value when rd=0.

Reset
REQ-036 While resetn=0: FSM=IDLE; line_base, addr, hold, shift register, byte_idx and bit count = 0; rd=0, pixel=0, active=0, line_done=0; edge-detect registers = 0.
REQ-037 Reset asserted mid-line aborts immediately; after release, the first line starts only on a fresh preload_rise.

Verification
REQ-038 width=32, graphics=1, base=0x100, mem returns addr[7:0]: fsn pulse then preload -> rd at addr 0x100..0x11F; active high for exactly 256 clocks, starting 8 clocks after preload_rise; pixel stream equals bytes 0x00..0x1F MSB first.
REQ-039 width=8: each bit is held 4 clocks and active spans 256 clocks; width=16: 2 clocks per bit, active spans 256 clocks.
REQ-040 graphics=0, width=32: three active lines with rowclear=0 -> all use line_base 0x100; a fourth line with rowclear=1 at hsn_fall -> the next line starts at 0x120.
REQ-041 base=0x1FF0, ADDR_W=13, width=32: rd addresses run 0x1FF0..0x1FFF, then 0x0000..0x000F.
REQ-042 fsn low during SHIFT -> active=0 on the next cycle and line_base=base; a second preload_rise during SHIFT produces no additional rd.
REQ-043 resetn low during SHIFT -> all outputs 0 immediately (asynchronous); no rd until the next preload_rise after release.

Source files
------------

// File: rtl/video_fetch.sv
// Display-memory line fetcher: reads one line of bytes per preload strobe
// and serialises them MSB first, stretching each pixel for narrow lines.
module video_fetch #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hsn,
  input  logic              fsn,
  input  logic              preload,
  input  logic              rowclear,
  input  logic [5:0]        width,
  input  logic              graphics,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              pixel,
  output logic              active
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT
  } fetchStateT;

  fetchStateT        state;
  fetchStateT        stateNext;

  logic              preloadPrev;
  logic              hsnPrev;
  logic              preloadRise;
  logic              hsnFall;

  logic [ADDR_W-1:0] lineBase;
  logic              lineDone;
  logic [7:0]        hold;
  logic [7:0]        shiftReg;
  logic              rdDly;
  logic [2:0]        waitCnt;
  logic [5:0]        byteIdx;
  logic [2:0]        bitCnt;
  logic [1:0]        divCnt;
  logic [1:0]        divMax;

  logic              lastDiv;
  logic              lastBit;
  logic              lastByte;
  logic              byteStart;
  logic              moreBytes;

  assign preloadRise = preload & ~preloadPrev;
  assign hsnFall     = ~hsn & hsnPrev;

  // Clocks per pixel minus one: narrower lines stretch pixels to fill the same span.
  always_comb begin
    case (width)
      6'd16:   divMax = 2'd1;
      6'd8:    divMax = 2'd3;
      default: divMax = 2'd0;
    endcase
  end

  assign lastDiv   = (divCnt == divMax);
  assign lastBit   = (bitCnt == 3'd7);
  assign lastByte  = (byteIdx == width - 6'd1);
  assign byteStart = (divCnt == 2'd0) && (bitCnt == 3'd0);
  assign moreBytes = (byteIdx < width - 6'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (preloadRise) stateNext = WAIT;
      WAIT:    if (waitCnt == 3'd7) stateNext = SHIFT;
      SHIFT:   if (lastDiv && lastBit && lastByte) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (!fsn) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      preloadPrev <= 1'b0;
      hsnPrev     <= 1'b0;
      lineBase    <= '0;
      lineDone    <= 1'b0;
      addr        <= '0;
      rd          <= 1'b0;
      rdDly       <= 1'b0;
      hold        <= '0;
      shiftReg    <= '0;
      pixel       <= 1'b0;
      active      <= 1'b0;
      waitCnt     <= '0;
      byteIdx     <= '0;
      bitCnt      <= '0;
      divCnt      <= '0;
    end else begin
      preloadPrev <= preload;
      hsnPrev     <= hsn;
      rd          <= 1'b0;
      rdDly       <= rd;
      // Memory answers one cycle after the strobe is seen.
      if (rdDly) hold <= mem_data;

      if (!fsn) begin
        lineBase <= base;
        lineDone <= 1'b0;
        active   <= 1'b0;
        pixel    <= 1'b0;
      end else begin
        if (hsnFall && lineDone) begin
          if (graphics || rowclear) lineBase <= lineBase + ADDR_W'(width);
          lineDone <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (preloadRise) begin
              rd      <= 1'b1;
              addr    <= lineBase;
              waitCnt <= 3'd1;
            end
          end
          WAIT: begin
            if (waitCnt == 3'd7) begin
              shiftReg <= hold;
              pixel    <= hold[7];
              active   <= 1'b1;
              byteIdx  <= '0;
              bitCnt   <= '0;
              divCnt   <= '0;
            end else begin
              waitCnt <= waitCnt + 3'd1;
            end
          end
          SHIFT: begin
            // Prefetch the next byte at the start of the current one.
            if (byteStart && moreBytes) begin
              rd   <= 1'b1;
              addr <= lineBase + ADDR_W'(byteIdx + 6'd1);
            end
            if (lastDiv) begin
              divCnt <= '0;
              if (lastBit) begin
                if (lastByte) begin
                  active   <= 1'b0;
                  pixel    <= 1'b0;
                  lineDone <= 1'b1;
                end else begin
                  byteIdx  <= byteIdx + 6'd1;
                  bitCnt   <= '0;
                  shiftReg <= hold;
                  pixel    <= hold[7];
                end
              end else begin
                bitCnt   <= bitCnt + 3'd1;
                shiftReg <= {shiftReg[6:0], 1'b0};
                pixel    <= shiftReg[6];
              end
            end else begin
              divCnt <= divCnt + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch; memory model returns the low address byte
// one cycle after each read strobe.
module tb_video_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hsn;
  logic        fsn;
  logic        preload;
  logic        rowclear;
  logic [5:0]  width;
  logic        graphics;
  logic [12:0] base;
  logic [7:0]  mem_data;
  logic [12:0] addr;
  logic        rd;
  logic        pixel;
  logic        active;

  int testsRun    = 0;
  int testsFailed = 0;

  video_fetch #(.ADDR_W(13)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .hsn      (hsn),
    .fsn      (fsn),
    .preload  (preload),
    .rowclear (rowclear),
    .width    (width),
    .graphics (graphics),
    .base     (base),
    .mem_data (mem_data),
    .addr     (addr),
    .rd       (rd),
    .pixel    (pixel),
    .active   (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= addr[7:0];

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic framePulse(input logic [12:0] newBase);
    @(negedge clk);
    base = newBase;
    fsn  = 1'b0;
    @(negedge clk);
    fsn = 1'b1;
  endtask

  task automatic hsync(input logic rc);
    @(negedge clk);
    hsn      = 1'b0;
    rowclear = rc;
    @(negedge clk);
    hsn      = 1'b1;
    rowclear = 1'b0;
  endtask

  // Runs one full line from a preload strobe and checks address sequence,
  // active window and serial pixel stream against the expected line base.
  task automatic runLine(input string tag, input logic [12:0] expBase, input int wdt, input int glitchAt);
    int div, rdCount, actCount, firstAct, pixErr, addrErr;
    logic [12:0] a;
    logic [7:0]  bv;
    logic        expPix;
    div      = (wdt == 32) ? 1 : ((wdt == 16) ? 2 : 4);
    rdCount  = 0;
    actCount = 0;
    firstAct = -1;
    pixErr   = 0;
    addrErr  = 0;
    @(negedge clk);
    width   = 6'(wdt);
    preload = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (rd) begin
        a = expBase + 13'(rdCount);
        if (addr !== a) addrErr++;
        rdCount++;
      end
      if (active) begin
        if (firstAct < 0) firstAct = c;
        a      = expBase + 13'(actCount / (8 * div));
        bv     = a[7:0];
        expPix = bv[7 - ((actCount / div) % 8)];
        if (pixel !== expPix) pixErr++;
        actCount++;
      end else if (pixel !== 1'b0) begin
        pixErr++;
      end
      if (c == 2) preload = 1'b0;
      if (c == glitchAt) preload = 1'b1;
      if (c == glitchAt + 1) preload = 1'b0;
    end
    check({tag, " rd count"}, rdCount, wdt);
    check({tag, " addr errors"}, addrErr, 0);
    check({tag, " first active"}, firstAct, 8);
    check({tag, " active span"}, actCount, 256);
    check({tag, " pixel errors"}, pixErr, 0);
  endtask

  initial begin
    int rdSeen;
    resetn   = 1'b0;
    hsn      = 1'b1;
    fsn      = 1'b1;
    preload  = 1'b0;
    rowclear = 1'b0;
    width    = 6'd32;
    graphics = 1'b1;
    base     = 13'h100;
    repeat (3) @(negedge clk);
    check("reset rd", rd, 0);
    check("reset active", active, 0);
    check("reset pixel", pixel, 0);
    check("reset addr", addr, 0);
    resetn = 1'b1;

    // Graphics mode: each completed line advances by width; blanking lines do not.
    framePulse(13'h100);
    runLine("g32 line0", 13'h100, 32, 0);
    hsync(1'b0);
    hsync(1'b0);
    runLine("g32 line1", 13'h120, 32, 0);

    framePulse(13'h100);
    runLine("g8", 13'h100, 8, 0);
    framePulse(13'h100);
    runLine("g16", 13'h100, 16, 0);

    // Alphanumeric mode: rows repeat until rowclear accompanies the hsync.
    graphics = 1'b0;
    framePulse(13'h100);
    runLine("a line0", 13'h100, 32, 0);
    hsync(1'b0);
    runLine("a line1", 13'h100, 32, 0);
    hsync(1'b0);
    runLine("a line2", 13'h100, 32, 0);
    hsync(1'b0);
    runLine("a line3", 13'h100, 32, 0);
    hsync(1'b1);
    runLine("a line4", 13'h120, 32, 0);

    graphics = 1'b1;
    framePulse(13'h1FF0);
    runLine("wrap", 13'h1FF0, 32, 0);

    framePulse(13'h100);
    runLine("reload glitch", 13'h100, 32, 60);

    // Frame sync in the middle of a line aborts it and reloads the base.
    framePulse(13'h100);
    @(negedge clk);
    preload = 1'b1;
    repeat (40) @(negedge clk);
    preload = 1'b0;
    check("pre-abort active", active, 1);
    base = 13'h200;
    fsn  = 1'b0;
    @(negedge clk);
    check("fsn abort active", active, 0);
    check("fsn abort pixel", pixel, 0);
    check("fsn abort rd", rd, 0);
    fsn = 1'b1;
    runLine("after fsn", 13'h200, 32, 0);

    // Asynchronous reset mid-line.
    framePulse(13'h100);
    @(negedge clk);
    preload = 1'b1;
    repeat (40) @(negedge clk);
    preload = 1'b0;
    check("pre-reset active", active, 1);
    #1 resetn = 1'b0;
    #1;
    check("async reset active", active, 0);
    check("async reset pixel", pixel, 0);
    check("async reset rd", rd, 0);
    check("async reset addr", addr, 0);
    @(negedge clk);
    resetn = 1'b1;
    rdSeen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rd) rdSeen++;
    end
    check("no rd after reset", rdSeen, 0);
    runLine("post reset", 13'h000, 32, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
